// File: rtl/spi_burst_master.sv
// SPI burst master: turns one host command into a header + N data byte frame on the shared slave bus.
// Optional SPI_MASTER_WR_READBACK_EN: capture the slave's old register contents (MSB first) during writes.
module spi_burst_master #(
    parameter int IDLE_CYCLES = 2
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       wr,
    input  logic [2:0] ext_addr,
    input  logic [2:0] reg_addr,
    input  logic [2:0] len,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       cs,
    output logic       mosi,
    input  logic       miso,
    input  logic       miso_oe
);

`ifdef SPI_MASTER_WR_READBACK_EN
    localparam logic READBACK = 1'b1;
`else
    localparam logic READBACK = 1'b0;
`endif

    localparam int GW = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_CYCLES - 2);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_GAP, S_FLUSH, S_IGAP} state_t;

    state_t        state_reg, state_next;
    logic [2:0]    slot_reg, slot_next;
    logic [2:0]    byte_reg, byte_next;
    logic [GW-1:0] gap_reg, gap_next;
    logic [7:0]    sh_reg, sh_next;
    logic          wr_reg, wr_next;
    logic [2:0]    len_reg, len_next;
    logic          cap_en_reg, cap_en_next;
    logic          cap_reg, cap_next;
    logic          last_reg, last_next;
    logic [7:0]    rx_sh_reg, rx_sh_next;
    logic [7:0]    rx_data_reg, rx_data_next;
    logic          rx_valid_reg, rx_valid_next;
    logic          cs_reg, cs_next;
    logic          mosi_reg, mosi_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;
    logic          load;
    logic          miso_bit;
    logic [7:0]    hdr_vec;

    // Header is kept MSB-first so header and write data share one left-shifting register.
    assign hdr_vec  = {wr, ext_addr[0], ext_addr[1], ext_addr[2], 1'b0,
                       reg_addr[0], reg_addr[1], reg_addr[2]};
    assign miso_bit = miso_oe & miso;
    assign tx_ready = wr_reg && ((state_reg == S_HDR && slot_reg == 3'd7) || state_reg == S_GAP);

    always_comb begin
        state_next    = state_reg;
        slot_next     = slot_reg;
        byte_next     = byte_reg;
        gap_next      = gap_reg;
        sh_next       = sh_reg;
        wr_next       = wr_reg;
        len_next      = len_reg;
        cap_en_next   = cap_en_reg;
        cs_next       = cs_reg;
        mosi_next     = mosi_reg;
        busy_next     = busy_reg;
        err_next      = err_reg;
        done_next     = 1'b0;
        load          = 1'b0;
        rx_sh_next    = rx_sh_reg;
        rx_data_next  = rx_data_reg;
        rx_valid_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next  = S_HDR;
                    slot_next   = 3'd0;
                    byte_next   = 3'd0;
                    sh_next     = {hdr_vec[6:0], 1'b0};
                    mosi_next   = hdr_vec[7];
                    cs_next     = 1'b1;
                    busy_next   = 1'b1;
                    err_next    = 1'b0;
                    wr_next     = wr;
                    len_next    = len;
                    cap_en_next = !wr || READBACK;
                end
            end
            S_HDR: begin
                if (slot_reg == 3'd7) begin
                    load = 1'b1;
                end else begin
                    slot_next = slot_reg + 3'd1;
                    mosi_next = sh_reg[7];
                    sh_next   = {sh_reg[6:0], 1'b0};
                end
            end
            S_DATA: begin
                if (slot_reg == 3'd7) begin
                    mosi_next = 1'b0;
                    if (byte_reg == len_reg) begin
                        state_next = S_FLUSH;
                        cs_next    = 1'b0;
                    end else begin
                        state_next = S_GAP;
                        byte_next  = byte_reg + 3'd1;
                    end
                end else begin
                    slot_next = slot_reg + 3'd1;
                    mosi_next = sh_reg[7];
                    sh_next   = {sh_reg[6:0], 1'b0};
                end
            end
            S_GAP: load = 1'b1;
            S_FLUSH: begin
                state_next = S_IGAP;
                gap_next   = '0;
                done_next  = 1'b1;
            end
            S_IGAP: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = S_IDLE;
                    busy_next  = 1'b0;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Byte load edge; a write with no byte on offer aborts the frame.
        if (load) begin
            if (wr_reg && !tx_valid) begin
                state_next = S_FLUSH;
                cs_next    = 1'b0;
                mosi_next  = 1'b0;
                err_next   = 1'b1;
            end else begin
                state_next = S_DATA;
                slot_next  = 3'd0;
                mosi_next  = wr_reg & tx_data[7];
                sh_next    = wr_reg ? {tx_data[6:0], 1'b0} : 8'h00;
            end
        end

        // Slot driven this cycle is sampled two edges later: cap_reg is the one-edge delay.
        cap_next  = cap_en_reg && (state_reg == S_DATA);
        last_next = (slot_reg == 3'd7);
        if (cap_reg) begin
            if (wr_reg)
                rx_sh_next = {rx_sh_reg[6:0], miso_bit};
            else
                rx_sh_next = {miso_bit, rx_sh_reg[7:1]};
            if (!miso_oe)
                err_next = 1'b1;
            if (last_reg) begin
                rx_data_next  = rx_sh_next;
                rx_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            slot_reg     <= 3'd0;
            byte_reg     <= 3'd0;
            gap_reg      <= '0;
            sh_reg       <= 8'h00;
            wr_reg       <= 1'b0;
            len_reg      <= 3'd0;
            cap_en_reg   <= 1'b0;
            cap_reg      <= 1'b0;
            last_reg     <= 1'b0;
            rx_sh_reg    <= 8'h00;
            rx_data_reg  <= 8'h00;
            rx_valid_reg <= 1'b0;
            cs_reg       <= 1'b0;
            mosi_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            slot_reg     <= slot_next;
            byte_reg     <= byte_next;
            gap_reg      <= gap_next;
            sh_reg       <= sh_next;
            wr_reg       <= wr_next;
            len_reg      <= len_next;
            cap_en_reg   <= cap_en_next;
            cap_reg      <= cap_next;
            last_reg     <= last_next;
            rx_sh_reg    <= rx_sh_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
            cs_reg       <= cs_next;
            mosi_reg     <= mosi_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign cs       = cs_reg;
    assign mosi     = mosi_reg;

endmodule

// File: doc/spi_burst_master.md
# spi_burst_master

Bus-side SPI master that drives the slave-mux bus (`cs`, `mosi`) and collects `miso`/`miso_oe` from the addressed slave. It converts one host command into a complete slave frame: header, one or more data bytes, and the inter-byte gap cycles the slaves expect. It sits directly upstream of the SPI slave register banks and shares their `sclk`. Burst transfers hit consecutive slave registers, with the register address wrapping 7→0 inside the slave.

## Interface
- `IDLE_CYCLES`, default 2: number of cs-low cycles after a frame before `busy` drops. Minimum 2.
- `sclk` in 1: the only clock, shared with all slaves. All logic runs on the posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: command request. Sampled only while `busy`=0.
- `wr` in 1: 1 = write, 0 = read.
- `ext_addr` in 3: slave select, compared by each slave against its `addr` strap.
- `reg_addr` in 3: first register address.
- `len` in 3: number of bytes minus 1 (1..8 bytes).
- `tx_data` in 8: write byte.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: combinational. High in the cycle whose closing edge loads a write byte.
- `rx_data` out 8: assembled read byte.
- `rx_valid` out 1: one-cycle strobe marking `rx_data` valid.
- `busy` out 1: a frame is in progress or the idle gap is running.
- `done` out 1: one-cycle strobe at frame end (normal or aborted).
- `err` out 1: sticky error flag. Cleared on an accepted `start`.
- `cs` out 1: active-high slave chip select.
- `mosi` out 1: serial data to the slaves.
- `miso` in 1: serial data from the slaves. Z when undriven.
- `miso_oe` in 1: the addressed slave is driving `miso`.

## Operation
- Reset values: `cs`, `mosi`, `busy`, `rx_valid`, `done`, `err` = 0; `rx_data` = 0x00; `tx_ready` = 0.
- States and transitions: IDLE → HDR (8 slots) → DATA (8 slots) → GAP (1 slot) → DATA … → FLUSH (1 cycle) → IGAP (`IDLE_CYCLES`) → IDLE.
- Header slot order: `wr`, `ext_addr[0]`, `ext_addr[1]`, `ext_addr[2]`, 0 (reserved), `reg_addr[0]`, `reg_addr[1]`, `reg_addr[2]`.
- Write data: sent MSB first, `d[7]`…`d[0]`.
- Read data: `mosi` = 0 in each data slot. Slaves return data LSB first, which the master reassembles into `rx_data[0..7]`.
- GAP slot between bytes: `mosi` = 0. The slave advances its register address during this slot.
- Byte counter: 3 bits, counts 0..`len`. There is no other width arithmetic; the register address is never modified in the master.
- Write underrun: if `tx_ready`=1 and `tx_valid`=0 at a load edge, the master aborts the frame:
  - `cs`←0 at that edge;
  - `err`←1;
  - FLUSH, then `done`, then IGAP.
- No responder: `miso_oe`=0 at any read-sample edge sets `err`. The sampled bit is taken as 0 and the frame continues.
- `start` while `busy`=1 is ignored.
- Asserting `rst_n` low mid-frame drops `cs` immediately and returns all outputs to their reset values.

## Timing
- Edge E is the edge that accepts `start`. At E: `cs`←1, `mosi`←`wr`, `busy`←1, `err`←0. Header slots are driven at E..E+7.
- Byte n (0..`len`):
  - first data slot driven at D_n = E+8+9n;
  - write byte loaded at D_n (`tx_ready` is high in the cycle ending at D_n);
  - GAP slot at D_n+8 when n<`len`.
- Read sampling is two edges behind the driven slot (slave sample edge + slave register edge). The bit for slot D_n+k is sampled at D_n+k+2.
- `rx_valid` is high for the cycle after edge D_n+9. Consecutive `rx_valid` strobes are 9 cycles apart.
- Last data slot T = E+8+9·`len`+7.
- `cs`←0 at T+1.
- The final read sample is taken at T+2, which is also the edge that raises `done`.
- `busy`←0 at T+1+`IDLE_CYCLES`.
- Frame length: 1-byte frame = 17 cs-high cycles; an 8-byte frame = 80 cs-high cycles.

## Configuration
- `SPI_MASTER_WR_READBACK_EN` defined: during writes, the master captures `miso` exactly as for reads, except MSB first (slaves return the old register contents). `rx_valid` then pulses per written byte with the previous register value.
- Undefined: during writes, `miso` is ignored, `rx_valid` never pulses, and `miso_oe` is not checked.

## Test plan
- Read, `ext_addr`=slave strap, `reg_addr`=5, `len`=0, register 5 = 0x75 → `rx_data`=0x75, one `rx_valid`, `done` at E+17, `err`=0.
- Burst read, `reg_addr`=7, `len`=1, register 7 = 0x35, register 0 = 0x12 → `rx_data` 0x35 then 0x12, 9 cycles apart (address wrap).
- Write 0xA5 to register 2 (old value 0x35), then read register 2 → read returns 0xA5. With `SPI_MASTER_WR_READBACK_EN`, the write also returns `rx_data`=0x35.
- Read with `ext_addr` matching no slave → `err`=1, `rx_data`=0x00, `done` still pulses at E+17.
- Write, `len`=2, `tx_valid` dropped at D_1 → `cs` low at D_1, byte 0 committed in the slave, `err`=1, `done` at D_1+1.
- `rst_n` low at E+10 of a read → `cs`, `mosi`, `busy` = 0 immediately. A new frame after release reads correct data.
